// File: rtl/serial_bmc_decoder.sv
// Biphase-mark (BMC) sweep-frame decoder: 17-bit word plus the frame-start timestamp.
// Optional `DECODER_ERR_CNT_EN adds err_count (aborted or dropped frames).
module serial_bmc_decoder #(
    parameter int HALF_BIT = 6
) (
    input  logic        clk_12MHz,
    input  logic        rstn,
    input  logic        envelope,
    input  logic        d_in,
    input  logic        reset_decoder,
    output logic        data_availible,
    output logic [16:0] decoded_data,
    output logic [23:0] timestamp_last_data
`ifdef DECODER_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic [2:0] {IDLE, SYNC, BITS, HOLD, ABORT} state_t;

    localparam logic [9:0] SHORT_MIN = 10'(HALF_BIT);
    localparam logic [9:0] LONG_MIN  = 10'(3 * HALF_BIT);
    localparam logic [9:0] LONG_MAX  = 10'(5 * HALF_BIT);

    state_t      state;
    logic        env_s1, env_s2, env_q;
    logic        d_s1, d_s2, d_q;
    logic [23:0] ts_cnt, frame_ts;
    logic [15:0] sr;
    logic [4:0]  bit_cnt;
    logic [7:0]  n;
    logic        pending;

    logic       env_rise, d_edge, is_short, is_long, bit_err, go_abort, drop;
    logic [9:0] n2;

    assign env_rise = env_s2 & ~env_q;
    assign d_edge   = d_s2 ^ d_q;
    assign n2       = {1'b0, n, 1'b0};
    assign is_short = (n2 >= SHORT_MIN) && (n2 < LONG_MIN);
    assign is_long  = (n2 >= LONG_MIN) && (n2 <= LONG_MAX);
    // A long with a half-bit still pending breaks the cell pairing.
    assign bit_err  = is_long ? pending : !is_short;
    assign drop     = (state == HOLD) && env_rise;

    always_comb begin
        go_abort = 1'b0;
        if (state == SYNC)
            go_abort = !env_s2;
        else if (state == BITS)
            go_abort = !env_s2 || (d_edge && bit_err) || (!d_edge && (n2 > LONG_MAX));
    end

    always_ff @(posedge clk_12MHz or negedge rstn) begin
        if (!rstn) begin
            state               <= IDLE;
            env_s1              <= 1'b0;
            env_s2              <= 1'b0;
            env_q               <= 1'b0;
            d_s1                <= 1'b0;
            d_s2                <= 1'b0;
            d_q                 <= 1'b0;
            ts_cnt              <= '0;
            frame_ts            <= '0;
            sr                  <= '0;
            bit_cnt             <= '0;
            n                   <= '0;
            pending             <= 1'b0;
            data_availible      <= 1'b0;
            decoded_data        <= '0;
            timestamp_last_data <= '0;
        end else begin
            env_s1 <= envelope;
            env_s2 <= env_s1;
            env_q  <= env_s2;
            d_s1   <= d_in;
            d_s2   <= d_s1;
            d_q    <= d_s2;
            ts_cnt <= ts_cnt + 24'd1;
            case (state)
                IDLE: if (env_rise) begin
                    frame_ts <= ts_cnt;
                    sr       <= '0;
                    bit_cnt  <= '0;
                    pending  <= 1'b0;
                    state    <= SYNC;
                end
                SYNC: begin
                    if (go_abort)
                        state <= ABORT;
                    else if (d_edge) begin
                        n     <= 8'd1;
                        state <= BITS;
                    end
                end
                BITS: begin
                    if (go_abort) begin
                        pending <= 1'b0;
                        state   <= ABORT;
                    end else if (d_edge) begin
                        n <= 8'd1;
                        if (is_short && !pending)
                            pending <= 1'b1;
                        else begin
                            // Long with nothing pending is a 0; the second short is a 1.
                            pending <= 1'b0;
                            sr      <= {sr[14:0], !is_long};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd16) begin
                                decoded_data        <= {sr, !is_long};
                                timestamp_last_data <= frame_ts;
                                data_availible      <= 1'b1;
                                state               <= HOLD;
                            end
                        end
                    end else if (n != 8'hFF)
                        n <= n + 8'd1;
                end
                HOLD: if (reset_decoder) begin
                    data_availible <= 1'b0;
                    state          <= IDLE;
                end
                ABORT: if (!env_s2)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DECODER_ERR_CNT_EN
    always_ff @(posedge clk_12MHz or negedge rstn) begin
        if (!rstn)
            err_count <= '0;
        else if ((go_abort || drop) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
